// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file constants: geometry and ABI register aliases.
package rv32i_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd1;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;
    localparam logic [REG_ADDR_W-1:0] REG_GP   = 5'd3;
    localparam logic [REG_ADDR_W-1:0] REG_TP   = 5'd4;
    localparam logic [REG_ADDR_W-1:0] REG_T0   = 5'd5;
    localparam logic [REG_ADDR_W-1:0] REG_T1   = 5'd6;
    localparam logic [REG_ADDR_W-1:0] REG_T2   = 5'd7;
    localparam logic [REG_ADDR_W-1:0] REG_S0   = 5'd8;
    localparam logic [REG_ADDR_W-1:0] REG_FP   = 5'd8;
    localparam logic [REG_ADDR_W-1:0] REG_S1   = 5'd9;
    localparam logic [REG_ADDR_W-1:0] REG_A0   = 5'd10;
    localparam logic [REG_ADDR_W-1:0] REG_A1   = 5'd11;
    localparam logic [REG_ADDR_W-1:0] REG_A2   = 5'd12;
    localparam logic [REG_ADDR_W-1:0] REG_A3   = 5'd13;
    localparam logic [REG_ADDR_W-1:0] REG_A4   = 5'd14;
    localparam logic [REG_ADDR_W-1:0] REG_A5   = 5'd15;
    localparam logic [REG_ADDR_W-1:0] REG_A6   = 5'd16;
    localparam logic [REG_ADDR_W-1:0] REG_A7   = 5'd17;
    localparam logic [REG_ADDR_W-1:0] REG_S2   = 5'd18;
    localparam logic [REG_ADDR_W-1:0] REG_S3   = 5'd19;
    localparam logic [REG_ADDR_W-1:0] REG_S4   = 5'd20;
    localparam logic [REG_ADDR_W-1:0] REG_S5   = 5'd21;
    localparam logic [REG_ADDR_W-1:0] REG_S6   = 5'd22;
    localparam logic [REG_ADDR_W-1:0] REG_S7   = 5'd23;
    localparam logic [REG_ADDR_W-1:0] REG_S8   = 5'd24;
    localparam logic [REG_ADDR_W-1:0] REG_S9   = 5'd25;
    localparam logic [REG_ADDR_W-1:0] REG_S10  = 5'd26;
    localparam logic [REG_ADDR_W-1:0] REG_S11  = 5'd27;
    localparam logic [REG_ADDR_W-1:0] REG_T3   = 5'd28;
    localparam logic [REG_ADDR_W-1:0] REG_T4   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_T5   = 5'd30;
    localparam logic [REG_ADDR_W-1:0] REG_T6   = 5'd31;

endpackage

// File: rtl/decoder_5_to_32.sv
// Write-enable decoder: out[i] = ena & (in == i); one-hot or all-zero.
module decoder_5_to_32 (
    input  logic        ena,
    input  logic [4:0]  in,
    output logic [31:0] out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < 32; i++) begin
            out[i] = ena && (in == 5'(i));
        end
    end

endmodule

// File: rtl/mux32.sv
// 32-way combinational read select; input i occupies in_bus[i*N +: N].
module mux32 #(
    parameter int N = 32
) (
    input  logic [32*N-1:0] in_bus,
    input  logic [4:0]      s,
    output logic [N-1:0]    out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < 32; i++) begin
            if (s == 5'(i)) begin
                out = in_bus[i*N +: N];
            end
        end
    end

endmodule

// File: rtl/register.sv
// N-bit storage flop with synchronous active-high reset and clock enable.
// Priority: rst > ena > hold.
module register #(
    parameter int            N           = 32,
    parameter logic [N-1:0]  RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_d;
    logic [N-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (ena) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/regfile_2r1w.sv
// RV32I integer register file: 31 stored registers (x1..x31), x0 hard-wired to zero,
// one clocked write port and two combinational read ports without write-through.
module regfile_2r1w
    import rv32i_pkg::*;
#(
    parameter int                     DATA_WIDTH  = XLEN,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_ena,
    input  logic [4:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [4:0]            rd_addr0,
    output logic [DATA_WIDTH-1:0] rd_data0,
    input  logic [4:0]            rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data1
);

    logic [REG_COUNT-1:0]            wr_en;
    logic [REG_COUNT*DATA_WIDTH-1:0] regs_bus;
    logic                            unused_wr_en0;

    decoder_5_to_32 u_wr_dec (
        .ena (wr_ena),
        .in  (wr_addr),
        .out (wr_en)
    );

    // x0 has no storage, so its decoded enable goes nowhere.
    assign unused_wr_en0           = wr_en[0];
    assign regs_bus[DATA_WIDTH-1:0] = '0;

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
        register #(
            .N           (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .ena (wr_en[i]),
            .d   (wr_data),
            .q   (regs_bus[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    mux32 #(.N(DATA_WIDTH)) u_rd_mux0 (
        .in_bus (regs_bus),
        .s      (rd_addr0),
        .out    (rd_data0)
    );

    mux32 #(.N(DATA_WIDTH)) u_rd_mux1 (
        .in_bus (regs_bus),
        .s      (rd_addr1),
        .out    (rd_data1)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed vector table, then a full sweep
// against a small reference model; expectations flow through a scoreboard queue.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;

    regfile_2r1w #(
        .DATA_WIDTH  (32),
        .RESET_VALUE (32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        r;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e0;
        logic [31:0] e1;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] model[32];

    function automatic string abi_name(input int i);
        string names[32] = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
                             "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
                             "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
                             "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};
        return names[i];
    endfunction

    function automatic void add(input string name, input logic r, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.name = name; v.r = r; v.we = we; v.wa = wa; v.wd = wd;
        v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
        vecs.push_back(v);
    endfunction

    // Drive one cycle; reads are checked just before the edge that commits the write.
    task automatic cyc(input string name, input logic r, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1);
        exp_t x;
        rst = r; wr_ena = we; wr_addr = wa; wr_data = wd;
        rd_addr0 = a0; rd_addr1 = a1;
        x.name = name; x.e0 = e0; x.e1 = e1;
        sb_q.push_back(x);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            x = sb_q.pop_front();
            n_vec++;
            if (rd_data0 !== x.e0) begin
                n_miss++;
                $display("FAIL %s port0 (addr %0d): got %h want %h", x.name, a0, rd_data0, x.e0);
            end
            n_vec++;
            if (rd_data1 !== x.e1) begin
                n_miss++;
                $display("FAIL %s port1 (addr %0d): got %h want %h", x.name, a1, rd_data1, x.e1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic print_state();
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            #1;
            $display("  x%0d (%s) = %h", i, abi_name(i), rd_data0);
        end
    endtask

    initial begin
        rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0;

        // name              r  we wa  wd            a0  a1  e0            e1
        add("reset_x0",      1, 0, 0,  32'h0,        0,  0,  32'h0,        32'h0);
        add("reset_clear",   0, 0, 0,  32'h0,        5,  5,  32'h0,        32'h0);
        add("wr_x5",         0, 1, 5,  32'hDEADBEEF, 5,  5,  32'h0,        32'h0);
        add("rst_pulse",     1, 0, 0,  32'h0,        5,  5,  32'hDEADBEEF, 32'hDEADBEEF);
        add("after_rst_x5",  0, 0, 0,  32'h0,        5,  5,  32'h0,        32'h0);
        add("wr_x1",         0, 1, 1,  32'h12345678, 1,  31, 32'h0,        32'h0);
        add("wr_x31",        0, 1, 31, 32'hFFFFFFFF, 1,  31, 32'h12345678, 32'h0);
        add("rd_x1_x31",     0, 0, 0,  32'h0,        1,  31, 32'h12345678, 32'hFFFFFFFF);
        add("rd_x2_x30",     0, 0, 0,  32'h0,        2,  30, 32'h0,        32'h0);
        add("x0_before",     0, 0, 0,  32'h0,        0,  31, 32'h0,        32'hFFFFFFFF);
        add("x0_during",     0, 1, 0,  32'hA5A5A5A5, 0,  0,  32'h0,        32'h0);
        add("x0_after",      0, 0, 0,  32'h0,        0,  1,  32'h0,        32'h12345678);
        add("gate_x7_a",     0, 0, 7,  32'h1,        7,  7,  32'h0,        32'h0);
        add("gate_x7_b",     0, 0, 7,  32'h1,        7,  7,  32'h0,        32'h0);
        add("gate_x7_c",     0, 0, 7,  32'h1,        7,  7,  32'h0,        32'h0);
        add("gate_x7_chk",   0, 0, 0,  32'h0,        7,  7,  32'h0,        32'h0);
        add("rst_beats_wr",  1, 1, 7,  32'h77,       1,  7,  32'h12345678, 32'h0);
        add("rst_beats_chk", 0, 0, 0,  32'h0,        7,  1,  32'h0,        32'h0);
        add("rdw_setup",     0, 1, 10, 32'h11,       10, 10, 32'h0,        32'h0);
        add("rdw_old",       0, 1, 10, 32'h22,       10, 10, 32'h11,       32'h11);
        add("rdw_new",       0, 0, 0,  32'h0,        10, 10, 32'h22,       32'h22);

        @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            cyc(vecs[k].name, vecs[k].r, vecs[k].we, vecs[k].wa, vecs[k].wd,
                vecs[k].a0, vecs[k].a1, vecs[k].e0, vecs[k].e1);
        end

        // Sweep: model starts from a fresh reset, then x[i] = i * 0x01010101.
        cyc("sweep_rst", 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            cyc("sweep_wr", 0, 1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(31 - i),
                model[i], model[31 - i]);
            model[i] = 32'(i) * 32'h01010101;
        end
        for (int i = 0; i < 32; i++) begin
            cyc("sweep_rd", 0, 0, 0, 32'h0, 5'(i), 5'(31 - i), model[i], model[31 - i]);
        end

        $display("Register state after sweep:");
        print_state();

        if (sb_q.size() != 0) begin
            n_vec++; n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
